// File: rtl/signal_bar_renderer.sv
// Multi-channel status-bar painter: repaints NUM_BARS filled rectangles one pixel per clock for vga_adapter.
// Optional feature macro AUTO_REFRESH_EN: repaint any bar whose live level differs from its last painted level.

module signal_bar_renderer #(
    parameter int                  NUM_BARS   = 3,
    parameter int                  BAR_W      = 75,
    parameter int                  BAR_H      = 10,
    parameter int                  X_W        = 10,
    parameter int                  Y_W        = 9,
    parameter int                  COLOUR_W   = 3,
    parameter logic [COLOUR_W-1:0] ON_COLOUR  = 3'b010,
    parameter logic [COLOUR_W-1:0] OFF_COLOUR = 3'b100
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_BARS-1:0]     signals,
    input  logic [NUM_BARS*X_W-1:0] bar_x,
    input  logic [NUM_BARS*Y_W-1:0] bar_y,
    input  logic                    draw,
    output logic [X_W-1:0]          out_x,
    output logic [Y_W-1:0]          out_y,
    output logic [COLOUR_W-1:0]     colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    localparam int IDX_W = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam int COL_W = (BAR_W > 1) ? $clog2(BAR_W) : 1;
    localparam int ROW_W = (BAR_H > 1) ? $clog2(BAR_H) : 1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(BAR_W - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BAR_H - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DRAW, DONE} state_e;

    state_e              state_q;
    logic [IDX_W-1:0]    idx_q;
    logic [NUM_BARS-1:0] pending_q, pending_d;
    logic [NUM_BARS-1:0] snap_q, snap_d;
    logic [NUM_BARS-1:0] chg, req, clr;
    logic                latch;

    logic [X_W-1:0]      ox_q;
    logic [Y_W-1:0]      oy_q;
    logic [COLOUR_W-1:0] fill_q;
    logic [COL_W-1:0]    col_q;
    logic [ROW_W-1:0]    row_q;

    logic [X_W-1:0]      out_x_q;
    logic [Y_W-1:0]      out_y_q;
    logic [COLOUR_W-1:0] colour_q;
    logic                plot_q;
    logic                done_q;

    logic [X_W-1:0]      bx [NUM_BARS];
    logic [Y_W-1:0]      by [NUM_BARS];

    for (genvar i = 0; i < NUM_BARS; i++) begin : g_unpack
        assign bx[i] = bar_x[i*X_W +: X_W];
        assign by[i] = bar_y[i*Y_W +: Y_W];
    end

    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        latch  = (state_q == SCAN) && pending_q[idx_q];
        snap_d = snap_q;
        clr    = '0;
        if (latch) begin
            snap_d[idx_q] = signals[idx_q];
            clr[idx_q]    = 1'b1;
        end
`ifdef AUTO_REFRESH_EN
        // Compared with snap_d so the bar being latched this cycle does not re-flag itself.
        chg = signals ^ snap_d;
`else
        chg = '0;
`endif
        req       = {NUM_BARS{draw}} | chg;
        pending_d = (pending_q & ~clr) | req;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '1;
            snap_q    <= '0;
            ox_q      <= '0;
            oy_q      <= '0;
            fill_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            out_x_q   <= '0;
            out_y_q   <= '0;
            colour_q  <= '0;
            plot_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here samples pre-edge values.
            pending_q <= pending_d;
            snap_q    <= snap_d;
            plot_q    <= (state_q == DRAW);
            done_q    <= (state_q == DONE);
            if (state_q == DRAW) begin
                out_x_q  <= ox_q + X_W'(col_q);
                out_y_q  <= oy_q + Y_W'(row_q);
                colour_q <= fill_q;
            end

            case (state_q)
                IDLE: begin
                    if ((pending_q | req) != '0) begin
                        state_q <= SCAN;
                        idx_q   <= '0;
                    end
                end
                SCAN: begin
                    if (pending_q[idx_q]) begin
                        ox_q    <= bx[idx_q];
                        oy_q    <= by[idx_q];
                        fill_q  <= signals[idx_q] ? ON_COLOUR : OFF_COLOUR;
                        col_q   <= '0;
                        row_q   <= '0;
                        state_q <= DRAW;
                    end else if (idx_q == LAST_IDX) begin
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DRAW: begin
                    if (col_q == LAST_COL) begin
                        col_q <= '0;
                        if (row_q == LAST_ROW) begin
                            row_q <= '0;
                            if (idx_q == LAST_IDX) begin
                                state_q <= DONE;
                            end else begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= SCAN;
                            end
                        end else begin
                            row_q <= row_q + 1'b1;
                        end
                    end else begin
                        col_q <= col_q + 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_x  = out_x_q;
    assign out_y  = out_y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign done   = done_q;
    assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_signal_bar_renderer.sv
// Self-checking bench for signal_bar_renderer: a monitor records every plotted pixel and each
// repaint pass is compared with a pixel list generated from bar geometry, levels and origins.

module tb_signal_bar_renderer;

    localparam int NB  = 3;
    localparam int BW  = 75;
    localparam int BH  = 10;
    localparam int PIX = BW * BH;
    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int PASS_BUSY = NB + NB * PIX + 1;

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    logic              clock = 1'b0;
    logic              reset;
    logic [NB-1:0]     signals;
    logic [NB*X_W-1:0] bar_x;
    logic [NB*Y_W-1:0] bar_y;
    logic              draw;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [2:0]        colour;
    logic              plot;
    logic              busy;
    logic              done;

    int n_cmp = 0;
    int n_err = 0;

    pix_t plots[$];
    pix_t expq[$];
    int   done_cyc[$];
    int   cyc         = 0;
    int   busy_cycles = 0;
    int   done_cnt    = 0;
    int   first_bad   = -1;

    logic [NB-1:0] cur_sig;
    int            cur_x[NB];
    int            cur_y[NB];

    always #5 clock = ~clock;

    signal_bar_renderer dut (
        .clock   (clock),
        .reset   (reset),
        .signals (signals),
        .bar_x   (bar_x),
        .bar_y   (bar_y),
        .draw    (draw),
        .out_x   (out_x),
        .out_y   (out_y),
        .colour  (colour),
        .plot    (plot),
        .busy    (busy),
        .done    (done)
    );

    always @(negedge clock) begin : monitor
        pix_t p;
        cyc = cyc + 1;
        if (plot === 1'b1) begin
            p.x   = int'(out_x);
            p.y   = int'(out_y);
            p.c   = int'(colour);
            p.cyc = cyc;
            plots.push_back(p);
        end
        if (busy === 1'b1) busy_cycles = busy_cycles + 1;
        if (done === 1'b1) begin
            done_cnt = done_cnt + 1;
            done_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic settle();
        repeat (20) tick();
    endtask

    task automatic drive_inputs();
        signals = cur_sig;
        for (int i = 0; i < NB; i++) begin
            bar_x[i*X_W +: X_W] = X_W'(cur_x[i]);
            bar_y[i*Y_W +: Y_W] = Y_W'(cur_y[i]);
        end
    endtask

    task automatic pulse_draw();
        draw = 1'b1;
        tick();
        draw = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_plots(input int target, input int budget);
        int n;
        n = 0;
        while (plots.size() < target && n < budget) begin
            tick();
            n++;
        end
    endtask

    // Reference: a pass paints flagged bars in ascending order, row-major, origin + offset modulo screen size.
    task automatic add_expected(input logic [NB-1:0] mask, input logic [NB-1:0] sig,
                                input int xs[NB], input int ys[NB]);
        pix_t p;
        for (int i = 0; i < NB; i++) begin
            if (mask[i]) begin
                for (int r = 0; r < BH; r++) begin
                    for (int c = 0; c < BW; c++) begin
                        p.x   = (xs[i] + c) % (1 << X_W);
                        p.y   = (ys[i] + r) % (1 << Y_W);
                        p.c   = sig[i] ? 2 : 4;
                        p.cyc = 0;
                        expq.push_back(p);
                    end
                end
            end
        end
    endtask

    function automatic int bad_pixels(input int base);
        int bad;
        bad       = 0;
        first_bad = -1;
        for (int k = 0; k < expq.size() && base + k < plots.size(); k++) begin
            if (plots[base+k].x != expq[k].x || plots[base+k].y != expq[k].y ||
                plots[base+k].c != expq[k].c ||
                (k % PIX != 0 && plots[base+k].cyc != plots[base+k-1].cyc + 1)) begin
                bad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        return bad;
    endfunction

    task automatic report_pixels(input string name, input int bad, input int base);
        if (first_bad >= 0)
            $display("FAIL %s pixels: %0d wrong, first at %0d got (%0d,%0d,c%0d,t%0d) required (%0d,%0d,c%0d)",
                     name, bad, first_bad, plots[base+first_bad].x, plots[base+first_bad].y,
                     plots[base+first_bad].c, plots[base+first_bad].cyc,
                     expq[first_bad].x, expq[first_bad].y, expq[first_bad].c);
    endtask

    task automatic test_reset();
        int base, bb, db, bad;
        reset   = 1'b1;
        draw    = 1'b0;
        cur_sig = 3'b101;
        cur_x   = '{40, 200, 500};
        cur_y   = '{10, 60, 300};
        drive_inputs();
        repeat (3) tick();
        n_cmp++;
        if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: plot/done/busy=%b%b%b required 000", plot, done, busy);
        end
        n_cmp++;
        if (out_x !== '0 || out_y !== '0 || colour !== '0) begin
            n_err++;
            $display("FAIL reset_pixel: x=%0d y=%0d colour=%0d required 0 0 0", out_x, out_y, colour);
        end
        base = plots.size(); bb = busy_cycles; db = done_cnt;
        reset = 1'b0;
        wait_done(db + 1, 4000);
        settle();
        expq.delete();
        add_expected(3'b111, cur_sig, cur_x, cur_y);
        n_cmp++;
        if (plots.size() - base !== expq.size()) begin
            n_err++;
            $display("FAIL reset_pass_count: plots=%0d required %0d", plots.size() - base, expq.size());
        end
        bad = bad_pixels(base);
        n_cmp++;
        if (bad !== 0) begin n_err++; report_pixels("reset_pass", bad, base); end
        n_cmp++;
        if (done_cnt - db !== 1 || busy_cycles - bb !== PASS_BUSY) begin
            n_err++;
            $display("FAIL reset_pass_timing: done=%0d busy=%0d required 1 %0d", done_cnt - db, busy_cycles - bb, PASS_BUSY);
        end
    endtask

    task automatic full_pass(input string name, output int base);
        int bb, db, bad;
        base = plots.size(); bb = busy_cycles; db = done_cnt;
        pulse_draw();
        wait_done(db + 1, 4000);
        settle();
        expq.delete();
        add_expected(3'b111, cur_sig, cur_x, cur_y);
        n_cmp++;
        if (plots.size() - base !== expq.size()) begin
            n_err++;
            $display("FAIL %s count: plots=%0d required %0d", name, plots.size() - base, expq.size());
        end
        bad = bad_pixels(base);
        n_cmp++;
        if (bad !== 0) begin n_err++; report_pixels(name, bad, base); end
        n_cmp++;
        if (done_cnt - db !== 1 || busy_cycles - bb !== PASS_BUSY) begin
            n_err++;
            $display("FAIL %s timing: done=%0d busy=%0d required 1 %0d", name, done_cnt - db, busy_cycles - bb, PASS_BUSY);
        end
    endtask

    task automatic test_draw_pulse();
        int base, fx, fy, lx, ly;
        cur_x = '{195, 195, 370};
        cur_y = '{95, 144, 119};
        drive_inputs();
        tick();
        full_pass("draw_pulse", base);
        fx = (plots.size() > base) ? plots[base].x : -1;
        fy = (plots.size() > base) ? plots[base].y : -1;
        lx = (plots.size() >= base + NB*PIX) ? plots[base+NB*PIX-1].x : -1;
        ly = (plots.size() >= base + NB*PIX) ? plots[base+NB*PIX-1].y : -1;
        n_cmp++;
        if (fx !== 195 || fy !== 95 || lx !== 444 || ly !== 128) begin
            n_err++;
            $display("FAIL draw_corners: first (%0d,%0d) last (%0d,%0d) required (195,95) (444,128)", fx, fy, lx, ly);
        end
    endtask

`ifdef AUTO_REFRESH_EN
    task automatic test_auto_refresh();
        int base, bb, db, bad;
        logic [NB-1:0] old_sig;
        base = plots.size(); bb = busy_cycles; db = done_cnt;
        cur_sig[1] = ~cur_sig[1];
        drive_inputs();
        wait_done(db + 1, 4000);
        settle();
        expq.delete();
        add_expected(3'b010, cur_sig, cur_x, cur_y);
        n_cmp++;
        if (plots.size() - base !== PIX || done_cnt - db !== 1 || busy_cycles - bb !== NB + PIX + 1) begin
            n_err++;
            $display("FAIL auto_single: plots=%0d done=%0d busy=%0d required %0d 1 %0d",
                     plots.size() - base, done_cnt - db, busy_cycles - bb, PIX, NB + PIX + 1);
        end
        bad = bad_pixels(base);
        n_cmp++;
        if (bad !== 0) begin n_err++; report_pixels("auto_single", bad, base); end

        base = plots.size(); bb = busy_cycles; db = done_cnt;
        old_sig = cur_sig;
        pulse_draw();
        wait_plots(base + 2*PIX + 100, 4000);
        cur_sig[0] = ~cur_sig[0];
        drive_inputs();
        wait_done(db + 2, 6000);
        settle();
        expq.delete();
        add_expected(3'b111, old_sig, cur_x, cur_y);
        add_expected(3'b001, cur_sig, cur_x, cur_y);
        n_cmp++;
        if (plots.size() - base !== expq.size() || done_cnt - db !== 2 ||
            busy_cycles - bb !== PASS_BUSY + NB + PIX + 1) begin
            n_err++;
            $display("FAIL auto_midpass: plots=%0d done=%0d busy=%0d required %0d 2 %0d",
                     plots.size() - base, done_cnt - db, busy_cycles - bb, expq.size(), PASS_BUSY + NB + PIX + 1);
        end
        bad = bad_pixels(base);
        n_cmp++;
        if (bad !== 0) begin n_err++; report_pixels("auto_midpass", bad, base); end
    endtask
`else
    task automatic test_no_refresh();
        int base, bb, db;
        logic [NB-1:0] painted;
        painted = cur_sig;
        base = plots.size(); bb = busy_cycles; db = done_cnt;
        for (int i = 0; i < 16; i++) begin
            cur_sig = NB'($urandom);
            drive_inputs();
            tick();
        end
        cur_sig = ~painted;
        drive_inputs();
        repeat (100) tick();
        n_cmp++;
        if (plots.size() - base !== 0 || done_cnt - db !== 0 || busy_cycles - bb !== 0) begin
            n_err++;
            $display("FAIL no_refresh_idle: plots=%0d done=%0d busy=%0d required 0 0 0",
                     plots.size() - base, done_cnt - db, busy_cycles - bb);
        end
        full_pass("no_refresh_draw", base);
    endtask
`endif

    task automatic test_random();
        int base;
        for (int it = 0; it < 4; it++) begin
            cur_sig = NB'($urandom);
            for (int i = 0; i < NB; i++) begin
                cur_x[i] = (it == 3) ? 1000 + i * 8 : int'($urandom_range(0, (1 << X_W) - 1));
                cur_y[i] = (it == 3) ? 505 : int'($urandom_range(0, (1 << Y_W) - 1));
            end
            drive_inputs();
            full_pass($sformatf("random%0d", it), base);
        end
    endtask

    task automatic test_live_inputs();
        int base, bb, db, bad;
        int xs[NB];
        int ys[NB];
        logic [NB-1:0] exp_sig;
        base = plots.size(); bb = busy_cycles; db = done_cnt;
        xs = cur_x; ys = cur_y;
        pulse_draw();
        wait_plots(base + 100, 2000);
        exp_sig = {NB'($urandom) & 3'b110} | (cur_sig & 3'b001);
        cur_sig = exp_sig;
        for (int i = 0; i < NB; i++) begin
            cur_x[i] = int'($urandom_range(0, (1 << X_W) - 1));
            cur_y[i] = int'($urandom_range(0, (1 << Y_W) - 1));
            if (i > 0) begin
                xs[i] = cur_x[i];
                ys[i] = cur_y[i];
            end
        end
        drive_inputs();
        wait_done(db + 1, 4000);
        settle();
        expq.delete();
        add_expected(3'b111, exp_sig, xs, ys);
        n_cmp++;
        if (plots.size() - base !== expq.size() || done_cnt - db !== 1) begin
            n_err++;
            $display("FAIL live_count: plots=%0d done=%0d required %0d 1", plots.size() - base, done_cnt - db, expq.size());
        end
        bad = bad_pixels(base);
        n_cmp++;
        if (bad !== 0) begin n_err++; report_pixels("live_inputs", bad, base); end
    endtask

    task automatic test_back_to_back();
        int base, bb, db, bad, gap1, gap2;
        base = plots.size(); bb = busy_cycles; db = done_cnt;
        draw = 1'b1;
        wait_done(db + 2, 6000);
        draw = 1'b0;
        wait_done(db + 3, 3000);
        settle();
        expq.delete();
        for (int p = 0; p < 3; p++) add_expected(3'b111, cur_sig, cur_x, cur_y);
        gap1 = (done_cyc.size() >= db + 2) ? done_cyc[db+1] - done_cyc[db] : -1;
        gap2 = (done_cyc.size() >= db + 3) ? done_cyc[db+2] - done_cyc[db+1] : -1;
        n_cmp++;
        if (gap1 !== PASS_BUSY + 1 || gap2 !== PASS_BUSY + 1) begin
            n_err++;
            $display("FAIL b2b_period: done spacing %0d %0d required %0d", gap1, gap2, PASS_BUSY + 1);
        end
        n_cmp++;
        if (plots.size() - base !== expq.size() || done_cnt - db !== 3 || busy_cycles - bb !== 3 * PASS_BUSY) begin
            n_err++;
            $display("FAIL b2b_count: plots=%0d done=%0d busy=%0d required %0d 3 %0d",
                     plots.size() - base, done_cnt - db, busy_cycles - bb, expq.size(), 3 * PASS_BUSY);
        end
        bad = bad_pixels(base);
        n_cmp++;
        if (bad !== 0) begin n_err++; report_pixels("back_to_back", bad, base); end
    endtask

    task automatic test_reset_mid_draw();
        int base, bb, db, bad, wx;
        cur_x = '{100, 1020, 300};
        cur_y = '{50, 200, 505};
        drive_inputs();
        tick();
        base = plots.size();
        pulse_draw();
        wait_plots(base + PIX + 300, 2000);
        #1 reset = 1'b1;
        #1;
        n_cmp++;
        if (plot !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: plot=%b busy=%b required 0 0", plot, busy);
        end
        tick();
        tick();
        base = plots.size(); bb = busy_cycles; db = done_cnt;
        reset = 1'b0;
        wait_done(db + 1, 4000);
        settle();
        expq.delete();
        add_expected(3'b111, cur_sig, cur_x, cur_y);
        n_cmp++;
        if (plots.size() - base !== expq.size() || done_cnt - db !== 1 || busy_cycles - bb !== PASS_BUSY) begin
            n_err++;
            $display("FAIL reset_repaint: plots=%0d done=%0d busy=%0d required %0d 1 %0d",
                     plots.size() - base, done_cnt - db, busy_cycles - bb, expq.size(), PASS_BUSY);
        end
        bad = bad_pixels(base);
        n_cmp++;
        if (bad !== 0) begin n_err++; report_pixels("reset_repaint", bad, base); end
        wx = (plots.size() > base + PIX + 5) ? plots[base+PIX+5].x : -1;
        n_cmp++;
        if (wx !== 1) begin
            n_err++;
            $display("FAIL x_wrap: bar1 col5 x=%0d required 1", wx);
        end
    endtask

    initial begin
        test_reset();
        test_draw_pulse();
`ifdef AUTO_REFRESH_EN
        test_auto_refresh();
`else
        test_no_refresh();
`endif
        test_random();
        test_live_inputs();
        test_back_to_back();
        test_reset_mid_draw();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
